// File: rtl/imm_pkg.sv
// Shared types and opcode constants for the pipelined immediate generator.
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_I       = 3'd0,
        FMT_S       = 3'd1,
        FMT_B       = 3'd2,
        FMT_U       = 3'd3,
        FMT_J       = 3'd4,
        FMT_NONE    = 3'd5,
        FMT_ILLEGAL = 3'd7
    } formato_t;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_FENCE    = 7'b0001111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;

    // Opcode to immediate format; anything unrecognised is ILLEGAL.
    function automatic formato_t decode_formato(input logic [6:0] opc);
        formato_t f;
        case (opc)
            OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM32,
            OPC_JALR, OPC_SYSTEM, OPC_FENCE:     f = FMT_I;
            OPC_STORE:                           f = FMT_S;
            OPC_BRANCH:                          f = FMT_B;
            OPC_LUI, OPC_AUIPC:                  f = FMT_U;
            OPC_JAL:                             f = FMT_J;
            OPC_OP, OPC_OP32:                    f = FMT_NONE;
            default:                             f = FMT_ILLEGAL;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/generador_imm_pipe_if.sv
// Instruction-in / immediate-out stream bundle for the immediate generator.
interface generador_imm_pipe_if
    import imm_pkg::*;
#(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned CNT_W = 16
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instruccion;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  inmediato;
    formato_t         formato;
    logic             ilegal;
    logic [CNT_W-1:0] cuenta_ilegal;

    modport master (
        output flush, in_valid, instruccion, out_ready,
        input  in_ready, out_valid, inmediato, formato, ilegal, cuenta_ilegal
    );

    modport slave (
        input  flush, in_valid, instruccion, out_ready,
        output in_ready, out_valid, inmediato, formato, ilegal, cuenta_ilegal
    );
endinterface

// File: rtl/imm_ensamblador.sv
// Combinational immediate assembly: instruction + format -> sign-extended XLEN value.
module imm_ensamblador
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [31:0]     instruccion,
    input  formato_t        formato,
    output logic [XLEN-1:0] inmediato_c
);
    logic [31:0] imm32;

    // Opcode bits never contribute to the immediate.
    logic unused_opcode;
    assign unused_opcode = ^instruccion[6:0];

    // Gather the format's immediate bits, already sign-extended to 32.
    always_comb begin
        imm32 = '0;
        case (formato)
            FMT_I: imm32 = {{20{instruccion[31]}}, instruccion[31:20]};
            FMT_S: imm32 = {{20{instruccion[31]}}, instruccion[31:25], instruccion[11:7]};
            FMT_B: imm32 = {{19{instruccion[31]}}, instruccion[31], instruccion[7],
                            instruccion[30:25], instruccion[11:8], 1'b0};
            FMT_U: imm32 = {instruccion[31:12], 12'b0};
            FMT_J: imm32 = {{11{instruccion[31]}}, instruccion[31], instruccion[19:12],
                            instruccion[20], instruccion[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign inmediato_c = XLEN'($signed(imm32));
endmodule

// File: rtl/generador_imm_pipe.sv
// Pipelined immediate generator: decode in stage 0, delay stages, assemble in the last stage.
module generador_imm_pipe
    import imm_pkg::*;
#(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned STAGES = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic clk,
    input  logic rst_n,
    generador_imm_pipe_if.slave bus
);
    localparam int LAST = int'(STAGES) - 1;

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] drain;
    logic [STAGES-1:0] load;
    logic [31:0]       src_instr;
    formato_t          src_fmt;
    logic [XLEN-1:0]   asm_imm;
    logic [XLEN-1:0]   inmediato_q;
    formato_t          formato_q;
    logic              ilegal_q;
    logic [CNT_W-1:0]  cuenta_q;

    // Ready/drain chain, combinational back from out_ready (no skid buffer).
    for (genvar k = 0; k < STAGES; k++) begin : g_ctl
        logic rdy;
        logic drn;
        if (k == LAST) begin : g_tail
            assign drn = v[k] & bus.out_ready;
        end else begin : g_body
            assign drn = v[k] & g_ctl[k+1].rdy;
        end
        assign rdy      = ~v[k] | drn;
        assign drain[k] = drn;
    end

    assign load[0] = bus.in_valid & g_ctl[0].rdy;
    for (genvar k = 1; k < STAGES; k++) begin : g_load
        assign load[k] = drain[k-1];
    end

    // Front stages carry the raw instruction and its decoded format.
    for (genvar k = 0; k < LAST; k++) begin : g_stage
        logic [31:0] instr_q;
        formato_t    fmt_q;
        logic [31:0] d_instr;
        formato_t    d_fmt;
        if (k == 0) begin : g_in
            assign d_instr = bus.instruccion;
            assign d_fmt   = decode_formato(bus.instruccion[6:0]);
        end else begin : g_dly
            assign d_instr = g_stage[k-1].instr_q;
            assign d_fmt   = g_stage[k-1].fmt_q;
        end

        // Stage data register, loaded when the stage accepts a new entry.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                instr_q <= '0;
                fmt_q   <= FMT_I;
            end else if (load[k] && !bus.flush) begin
                instr_q <= d_instr;
                fmt_q   <= d_fmt;
            end
        end
    end

    // Last stage source: the input itself when single-stage, otherwise the previous stage.
    if (STAGES == 1) begin : g_src_in
        assign src_instr = bus.instruccion;
        assign src_fmt   = decode_formato(bus.instruccion[6:0]);
    end else begin : g_src_reg
        assign src_instr = g_stage[LAST-1].instr_q;
        assign src_fmt   = g_stage[LAST-1].fmt_q;
    end

    imm_ensamblador #(.XLEN(XLEN)) u_ensamblador (
        .instruccion (src_instr),
        .formato     (src_fmt),
        .inmediato_c (asm_imm)
    );

    // Valid bits: flush wipes everything, otherwise fill on load and empty on drain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
        end else if (bus.flush) begin
            v <= '0;
        end else begin
            v <= load | (v & ~drain);
        end
    end

    // Output register holds the assembled result until it is consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inmediato_q <= '0;
            formato_q   <= FMT_I;
            ilegal_q    <= 1'b0;
        end else if (load[LAST] && !bus.flush) begin
            inmediato_q <= asm_imm;
            formato_q   <= src_fmt;
            ilegal_q    <= (src_fmt == FMT_ILLEGAL);
        end
    end

    // Saturating count of illegal results handed to the consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cuenta_q <= '0;
        end else if (!bus.flush && drain[LAST] && ilegal_q && (cuenta_q != {CNT_W{1'b1}})) begin
            cuenta_q <= cuenta_q + CNT_W'(1);
        end
    end

    assign bus.in_ready      = g_ctl[0].rdy | bus.flush;
    assign bus.out_valid     = v[LAST];
    assign bus.inmediato     = inmediato_q;
    assign bus.formato       = formato_q;
    assign bus.ilegal        = ilegal_q;
    assign bus.cuenta_ilegal = cuenta_q;
endmodule

// File: doc/generador_imm_pipe.md
Name: generador_imm_pipe

Overview:
- Pipelined, parametrised successor to the combinational immediate generator.
- Takes a stream of 32-bit RISC-V instructions over a valid/ready handshake, classifies the format, and emits the XLEN-wide sign-extended immediate with a format code and an illegal-opcode flag.
- Keeps a saturating count of illegal instructions delivered.
- Sits between instruction fetch/decode and the ALU operand mux.

Parameters:
- XLEN, 64, immediate output width; legal values 32 or 64.
- STAGES, 2, pipeline depth and capacity in instructions; legal range 1..4.
- CNT_W, 16, width of the illegal-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous pipeline clear.
- in_valid  in  1  instruccion is valid.
- in_ready  out  1  block accepts an instruction this cycle.
- instruccion  in  32  instruction word.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- inmediato  out  XLEN  sign-extended immediate.
- formato  out  3  0=I, 1=S, 2=B, 3=U, 4=J, 5=NONE (R-type), 7=ILLEGAL.
- ilegal  out  1  opcode not recognised.
- cuenta_ilegal  out  CNT_W  saturating count of illegal results delivered.

Behaviour:
- Reset: while rst_n=0, all stage valid bits, out_valid, inmediato, formato, ilegal and cuenta_ilegal are 0. in_ready is 1 from the first edge after release.
- Pipeline: STAGES registers, each holding {valid, data}.
  - Stage k loads from stage k-1 when stage k is empty or is being drained in the same cycle.
  - Last-stage drain condition: out_valid & out_ready.
  - in_ready = ~v[0] | advance[0]. The enable chain is combinational from out_ready (no skid).
  - Capacity is STAGES instructions. With out_ready held at 1, throughput is 1 per cycle and latency is STAGES cycles from the in_valid&in_ready edge to out_valid.
- Stage 0 captures the instruction and decodes the format from opcode[6:0]:
  - I: 0000011, 0010011, 0011011, 1100111, 1110011, 0001111
  - S: 0100011
  - B: 1100011
  - U: 0110111, 0010111
  - J: 1101111
  - NONE: 0110011, 0111011
  - any other opcode: ILLEGAL
- Last stage assembles the immediate and sign-extends from instruccion[31] to XLEN:
  - I = [31:20]
  - S = {[31:25],[11:7]}
  - B = {[31],[7],[30:25],[11:8],0}
  - U = {[31:12],12'b0}
  - J = {[31],[19:12],[20],[30:21],0}
  - NONE and ILLEGAL give inmediato = 0. ilegal = 1 only for ILLEGAL.
- Intermediate stages (STAGES>2) are pure delay. With STAGES=1, decode and assembly happen in the single stage.
- Outputs hold stable while out_valid=1 and out_ready=0.
- flush:
  - Clears every valid bit at the next edge.
  - An input presented in the flush cycle is dropped; in_ready is 1 during flush.
  - cuenta_ilegal is unaffected.
  - flush takes priority over any handshake.
- cuenta_ilegal increments by 1 on each cycle where out_valid & out_ready & ilegal, and saturates at 2^CNT_W-1.
- Reset mid-stream discards all in-flight instructions immediately (asynchronous).

Decomposition:
- Shared package imm_pkg holds:
  - the formato_t enum (3 bits, values above)
  - opcode localparams (OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM32, OPC_JALR, OPC_SYSTEM, OPC_FENCE, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_OP, OPC_OP32)
- One natural sub-module, imm_ensamblador: combinational {instruccion, formato} -> XLEN immediate. It is instantiated in the last stage and is reusable by the decoder.

Test Plan:
- STAGES=2, XLEN=64, out_ready=1: 0x01400093 (addi x1,x0,20) -> 2 cycles later out_valid=1, inmediato=0x14, formato=0, ilegal=0.
- Back-to-back 0xFE20AC23 (sw, -8) then 0xFE000EE3 (beq, -4) -> consecutive cycles 0xFFFFFFFFFFFFFFF8 fmt 1, then 0xFFFFFFFFFFFFFFFC fmt 2.
- 0x800000B7 (lui) -> 0xFFFFFFFF80000000 fmt 3 (XLEN=32: 0x80000000). 0x0010006F (jal +2048) -> 0x800 fmt 4. 0x00000033 -> 0 fmt 5.
- Backpressure: out_ready=0, offer 4 instructions -> only 2 accepted, in_ready=0 afterwards, outputs stable. Raise out_ready -> all 4 emerge in order, none lost or duplicated.
- Illegal path: 0x0000007F three times, with one flushed mid-pipe -> ilegal=1, imm=0, cuenta_ilegal=2. With CNT_W=2, five delivered illegals -> counter saturates at 3.
- Assert rst_n=0 asynchronously with 2 in flight -> out_valid and counter drop to 0 before the next edge. After release, the first new instruction emerges with correct latency.
